// File: rtl/pacman_pkg.sv
// Shared types for the pacman game sequencer: direction and game-state encodings,
// BCD limits, and the button-to-direction priority resolver.
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WIN  = 2'b10,
    ST_LOSE = 2'b11
  } game_state_t;

  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
  localparam logic [15:0] BCD_SAT       = {4{BCD_MAX_DIGIT}};

  // Simultaneous requests resolve UP > DOWN > LEFT > RIGHT.
  function automatic dir_t btn_to_dir(input logic up, input logic down, input logic left);
    dir_t d;
    d = DIR_RIGHT;
    if (left) d = DIR_LEFT;
    if (down) d = DIR_DOWN;
    if (up)   d = DIR_UP;
    return d;
  endfunction

endpackage

// File: rtl/pacman_game_ctrl_if.sv
// Signal bundle between the game sequencer and its surroundings (debouncers,
// movement datapath, collision logic, score display).
interface pacman_game_ctrl_if;

  logic        start;
  logic        ack;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        tile_aligned;
  logic [3:0]  wall_block;
  logic        dot_eaten;
  logic        ghost_hit;
  logic        move_en;
  logic [1:0]  move_dir;
  logic [1:0]  game_state;
  logic [15:0] score;
  logic        win;
  logic        lose;

  modport master (
    output start, ack, btn_up, btn_down, btn_left, btn_right,
    output tile_aligned, wall_block, dot_eaten, ghost_hit,
    input  move_en, move_dir, game_state, score, win, lose
  );

  modport slave (
    input  start, ack, btn_up, btn_down, btn_left, btn_right,
    input  tile_aligned, wall_block, dot_eaten, ghost_hit,
    output move_en, move_dir, game_state, score, win, lose
  );

endinterface

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear, saturating at 9999.
module bcd_counter4
  import pacman_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_inc,
  output logic [15:0] o_bcd
);

  logic [15:0] r_bcd;
  logic [15:0] w_inc_val;
  logic        w_carry;
  logic        w_sat;

  // Ripple the +1 through the digits; a digit at 9 wraps to 0 and passes the carry on.
  always_comb begin
    w_inc_val = r_bcd;
    w_carry   = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_bcd[4*i +: 4] == BCD_MAX_DIGIT) begin
          w_inc_val[4*i +: 4] = 4'd0;
        end else begin
          w_inc_val[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
          w_carry             = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_sat = (r_bcd == BCD_SAT);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bcd <= '0;
    end else if (i_clr) begin
      r_bcd <= '0;
    end else if (i_inc && !w_sat) begin
      r_bcd <= w_inc_val;
    end
  end

  assign o_bcd = r_bcd;

endmodule

// File: rtl/pacman_game_ctrl.sv
// Pacman game sequencer: IDLE/PLAY/WIN/LOSE flow, move-rate strobe, tile-boundary
// direction changes, BCD score and dot count.
module pacman_game_ctrl
  import pacman_pkg::*;
#(
  parameter int unsigned MOVE_DIV  = 524288,
  parameter int unsigned DOT_TOTAL = 244
)(
  input  logic               clk,
  input  logic               reset_n,
  pacman_game_ctrl_if.slave  bus
);

  localparam int unsigned     TW        = $clog2(MOVE_DIV);
  localparam logic [TW-1:0]   TICK_LAST = TW'(MOVE_DIV - 1);
  localparam logic [13:0]     DOT_LAST  = 14'(DOT_TOTAL - 1);

  game_state_t   r_state;
  game_state_t   w_next_state;
  logic [TW-1:0] r_tick_cnt;
  logic [13:0]   r_dot_cnt;
  dir_t          r_move_dir;
  dir_t          r_pend_dir;
  logic          r_pend_v;
  logic          r_move_en;

  logic          w_play;
  logic          w_start_game;
  logic          w_tick;
  logic          w_btn_any;
  dir_t          w_btn_dir;
  logic          w_apply;
  dir_t          w_new_dir;
  logic          w_dot;
  logic          w_final_dot;
  logic [15:0]   w_score;

  always_comb begin
    w_play       = (r_state == ST_PLAY);
    w_start_game = (r_state == ST_IDLE) && bus.start;
    w_tick       = w_play && (r_tick_cnt == TICK_LAST);
    w_btn_any    = w_play && (bus.btn_up || bus.btn_down || bus.btn_left || bus.btn_right);
    w_btn_dir    = btn_to_dir(bus.btn_up, bus.btn_down, bus.btn_left);
    w_apply      = w_tick && bus.tile_aligned && r_pend_v && !bus.wall_block[r_pend_dir];
    w_new_dir    = w_apply ? r_pend_dir : r_move_dir;
    w_dot        = w_play && bus.dot_eaten;
    w_final_dot  = w_dot && (r_dot_cnt == DOT_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A ghost on the same cycle as the final dot takes priority over the win.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (bus.start) w_next_state = ST_PLAY;
      ST_PLAY: begin
        if (bus.ghost_hit)    w_next_state = ST_LOSE;
        else if (w_final_dot) w_next_state = ST_WIN;
      end
      ST_WIN:  if (bus.ack)   w_next_state = ST_IDLE;
      ST_LOSE: if (bus.ack)   w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // The strobe is suppressed when the same edge leaves PLAY, so non-PLAY states never see it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_move_en <= 1'b0;
    end else begin
      r_move_en <= w_tick && (w_next_state == ST_PLAY)
                   && (!bus.tile_aligned || !bus.wall_block[w_new_dir]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
      r_dot_cnt  <= '0;
      r_move_dir <= DIR_LEFT;
      r_pend_dir <= DIR_LEFT;
      r_pend_v   <= 1'b0;
    end else if (w_start_game) begin
      r_tick_cnt <= '0;
      r_dot_cnt  <= '0;
      r_move_dir <= DIR_LEFT;
      r_pend_v   <= 1'b0;
    end else if (w_play) begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      if (w_apply) r_move_dir <= r_pend_dir;
      // A fresh request outranks consuming the old one, so a press during the tick cycle survives.
      if (w_btn_any) begin
        r_pend_dir <= w_btn_dir;
        r_pend_v   <= 1'b1;
      end else if (w_apply) begin
        r_pend_v   <= 1'b0;
      end
      if (w_dot) r_dot_cnt <= r_dot_cnt + 14'd1;
    end
  end

  bcd_counter4 u_score (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_clr   (w_start_game),
    .i_inc   (w_dot),
    .o_bcd   (w_score)
  );

  assign bus.move_en    = r_move_en;
  assign bus.move_dir   = r_move_dir;
  assign bus.game_state = r_state;
  assign bus.score      = w_score;
  assign bus.win        = (r_state == ST_WIN);
  assign bus.lose       = (r_state == ST_LOSE);

endmodule

// File: tb/tb_pacman_game_ctrl.sv
// Directed scoreboard bench for pacman_game_ctrl (MOVE_DIV=4, DOT_TOTAL=3) and its BCD counter.
module tb_pacman_game_ctrl;

  logic clk;
  logic reset_n;
  logic bcd_clr;
  logic bcd_inc;
  logic [15:0] bcd_out;

  int n_checks;
  int n_errors;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  pacman_game_ctrl_if bus ();

  pacman_game_ctrl #(
    .MOVE_DIV  (4),
    .DOT_TOTAL (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  bcd_counter4 u_bcd (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_clr   (bcd_clr),
    .i_inc   (bcd_inc),
    .o_bcd   (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $error("FAIL sb_empty: observed %h with no expected value queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    sb_push(tag, exp);
    sb_check(obs);
  endtask

  task automatic to_next_tick(input logic [3:0] btn);
    {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = btn;
    cyc();
    {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = 4'b0000;
    repeat (3) cyc();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0;
    bcd_clr = 1'b0;
    bcd_inc = 1'b0;
    bus.start = 1'b0;
    bus.ack = 1'b0;
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b0;
    bus.tile_aligned = 1'b1;
    bus.wall_block = 4'b0000;
    bus.dot_eaten = 1'b0;
    bus.ghost_hit = 1'b0;

    repeat (3) cyc();
    chk("rst_state", 32'(bus.game_state), 0);
    chk("rst_move_en", 32'(bus.move_en), 0);
    chk("rst_move_dir", 32'(bus.move_dir), 2);
    chk("rst_score", 32'(bus.score), 0);
    chk("rst_win", 32'(bus.win), 0);
    chk("rst_lose", 32'(bus.lose), 0);
    reset_n = 1'b1;
    cyc();
    chk("idle_hold", 32'(bus.game_state), 0);

    // Start: strobe every 4th cycle, heading LEFT.
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("start_state", 32'(bus.game_state), 1);
    chk("start_dir", 32'(bus.move_dir), 2);
    chk("start_en", 32'(bus.move_en), 0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      sb_push($sformatf("tick_en_%0d", k), (k % 4 == 0) ? 32'd1 : 32'd0);
      sb_check(32'(bus.move_en));
    end

    // UP request applied on the next tick.
    to_next_tick(4'b1000);
    chk("up_dir", 32'(bus.move_dir), 0);
    chk("up_en", 32'(bus.move_en), 1);

    // RIGHT requested but blocked, current UP also blocked: stall.
    bus.wall_block = 4'b1001;
    to_next_tick(4'b0001);
    chk("blk_dir", 32'(bus.move_dir), 0);
    chk("blk_en", 32'(bus.move_en), 0);
    bus.wall_block = 4'b0000;
    to_next_tick(4'b0000);
    chk("unblk_dir", 32'(bus.move_dir), 3);
    chk("unblk_en", 32'(bus.move_en), 1);

    // Request in the tick cycle itself waits one more period.
    repeat (3) cyc();
    bus.btn_down = 1'b1;
    cyc();
    bus.btn_down = 1'b0;
    chk("late_dir", 32'(bus.move_dir), 3);
    chk("late_en", 32'(bus.move_en), 1);
    repeat (4) cyc();
    chk("late_dir2", 32'(bus.move_dir), 1);
    chk("late_en2", 32'(bus.move_en), 1);

    // LEFT beats RIGHT when both pulse together.
    to_next_tick(4'b0011);
    chk("prio_dir", 32'(bus.move_dir), 2);
    chk("prio_en", 32'(bus.move_en), 1);

    // Three dots win.
    bus.dot_eaten = 1'b1;
    cyc();
    chk("dot1_score", 32'(bus.score), 32'h0001);
    cyc();
    cyc();
    bus.dot_eaten = 1'b0;
    chk("win_state", 32'(bus.game_state), 2);
    chk("win_flag", 32'(bus.win), 1);
    chk("win_lose", 32'(bus.lose), 0);
    chk("win_score", 32'(bus.score), 32'h0003);
    chk("win_en", 32'(bus.move_en), 0);
    bus.dot_eaten = 1'b1;
    bus.start = 1'b1;
    bus.btn_up = 1'b1;
    cyc();
    bus.dot_eaten = 1'b0;
    bus.start = 1'b0;
    bus.btn_up = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("win_en_%0d", k), 32'(bus.move_en), 0);
    end
    chk("win_frz_score", 32'(bus.score), 32'h0003);
    chk("win_frz_state", 32'(bus.game_state), 2);
    chk("win_frz_dir", 32'(bus.move_dir), 2);
    bus.ack = 1'b1;
    cyc();
    bus.ack = 1'b0;
    chk("ack_state", 32'(bus.game_state), 0);
    chk("ack_score", 32'(bus.score), 32'h0003);
    chk("ack_win", 32'(bus.win), 0);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("restart_state", 32'(bus.game_state), 1);
    chk("restart_score", 32'(bus.score), 32'h0000);
    chk("restart_dir", 32'(bus.move_dir), 2);

    // Ghost coinciding with the final dot: dot scored, LOSE.
    bus.dot_eaten = 1'b1;
    cyc();
    cyc();
    bus.ghost_hit = 1'b1;
    cyc();
    bus.dot_eaten = 1'b0;
    bus.ghost_hit = 1'b0;
    chk("lose_state", 32'(bus.game_state), 3);
    chk("lose_flag", 32'(bus.lose), 1);
    chk("lose_win", 32'(bus.win), 0);
    chk("lose_score", 32'(bus.score), 32'h0003);
    bus.ack = 1'b1;
    bus.start = 1'b1;
    cyc();
    bus.ack = 1'b0;
    bus.start = 1'b0;
    chk("ackstart_state", 32'(bus.game_state), 0);
    bus.ack = 1'b1;
    cyc();
    bus.ack = 1'b0;
    chk("idle_ack_state", 32'(bus.game_state), 0);
    chk("idle_ack_score", 32'(bus.score), 32'h0003);

    // Mid-game reset while the strobe is high.
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.btn_up = 1'b1;
    bus.dot_eaten = 1'b1;
    cyc();
    bus.btn_up = 1'b0;
    bus.dot_eaten = 1'b0;
    repeat (3) cyc();
    chk("pre_rst_en", 32'(bus.move_en), 1);
    chk("pre_rst_dir", 32'(bus.move_dir), 0);
    chk("pre_rst_score", 32'(bus.score), 32'h0001);
    reset_n = 1'b0;
    #2;
    chk("arst_state", 32'(bus.game_state), 0);
    chk("arst_en", 32'(bus.move_en), 0);
    chk("arst_dir", 32'(bus.move_dir), 2);
    chk("arst_score", 32'(bus.score), 0);
    chk("arst_win", 32'(bus.win), 0);
    chk("arst_lose", 32'(bus.lose), 0);
    cyc();
    reset_n = 1'b1;
    repeat (4) cyc();
    chk("post_rst_en", 32'(bus.move_en), 0);
    chk("post_rst_state", 32'(bus.game_state), 0);

    // BCD counter carries and saturation.
    bcd_inc = 1'b1;
    for (int i = 1; i <= 10002; i++) begin
      cyc();
      if (i == 10)    chk("bcd_10", 32'(bcd_out), 32'h0010);
      if (i == 100)   chk("bcd_100", 32'(bcd_out), 32'h0100);
      if (i == 1234)  chk("bcd_1234", 32'(bcd_out), 32'h1234);
      if (i == 9999)  chk("bcd_9999", 32'(bcd_out), 32'h9999);
      if (i == 10002) chk("bcd_sat", 32'(bcd_out), 32'h9999);
    end
    bcd_inc = 1'b0;
    bcd_clr = 1'b1;
    cyc();
    bcd_clr = 1'b0;
    chk("bcd_clr", 32'(bcd_out), 32'h0000);

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
